// File: rtl/video_line_filler.sv
// Line-length normaliser: pads short active lines and truncates long ones to H_DISP pixels,
// with frame-synchronous enable and per-frame pad/truncate/overrun statistics.
module video_line_filler #(
    parameter int H_DISP = 1280,
    parameter int DATA_W = 24,
    parameter int STAT_W = 16
) (
    input  logic              pre_clk,
    input  logic              rst,
    input  logic              EN,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] color,
    input  logic              pre_vs,
    input  logic              pre_de,
    input  logic [DATA_W-1:0] pre_data,
    output logic              post_clk,
    output logic              post_vs,
    output logic              post_de,
    output logic [DATA_W-1:0] post_data,
    output logic [STAT_W-1:0] stat_pad,
    output logic [STAT_W-1:0] stat_trunc,
    output logic              stat_ovr
);
    typedef enum logic [1:0] {BYPASS, RECV, FILL} state_t;

    localparam logic [11:0] H_LIM = 12'(H_DISP);

    state_t            state;
    logic              vs_p0;
    logic              de_p0;
    logic [11:0]       h_cnt;
    logic [DATA_W-1:0] last_pix;
    logic [STAT_W-1:0] pad_cnt;
    logic [STAT_W-1:0] trunc_cnt;
    logic              ovr_flag;
    logic              trunc_seen;

    logic              vs_rise;
    logic              de_rise;
    logic              de_fall;
    logic [11:0]       idx;
    logic [11:0]       h_inc;
    logic [DATA_W-1:0] fill_val;

    function automatic logic [11:0] inc_h(input logic [11:0] x);
        return (x == 12'hFFF) ? x : x + 12'd1;
    endfunction

    function automatic logic [STAT_W-1:0] inc_stat(input logic [STAT_W-1:0] x);
        return (x == {STAT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] fill_pix(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] c,
                                                   input logic [DATA_W-1:0] lp);
        case (m)
            2'b00:   return lp;
            2'b01:   return '0;
            2'b10:   return '1;
            default: return c;
        endcase
    endfunction

    assign post_clk = pre_clk;
    assign vs_rise  = pre_vs & ~vs_p0;
    assign de_rise  = pre_de & ~de_p0;
    assign de_fall  = ~pre_de & de_p0;
    // A rising DE restarts the index so the first pixel of a line is always index 0.
    assign idx      = de_rise ? 12'd0 : h_cnt;
    assign h_inc    = inc_h(h_cnt);
    assign fill_val = fill_pix(mode, color, last_pix);

    // Single registered stage: every output is one pre_clk behind its input.
    always_ff @(posedge pre_clk) begin
        if (rst) begin
            state      <= BYPASS;
            vs_p0      <= 1'b0;
            de_p0      <= 1'b0;
            h_cnt      <= '0;
            last_pix   <= '0;
            pad_cnt    <= '0;
            trunc_cnt  <= '0;
            ovr_flag   <= 1'b0;
            trunc_seen <= 1'b0;
            post_vs    <= 1'b0;
            post_de    <= 1'b0;
            post_data  <= '0;
            stat_pad   <= '0;
            stat_trunc <= '0;
            stat_ovr   <= 1'b0;
        end else begin
            vs_p0   <= pre_vs;
            de_p0   <= pre_de;
            post_vs <= pre_vs;
            if (vs_rise) begin
                stat_pad   <= pad_cnt;
                stat_trunc <= trunc_cnt;
                stat_ovr   <= ovr_flag;
                pad_cnt    <= '0;
                trunc_cnt  <= '0;
                ovr_flag   <= 1'b0;
                h_cnt      <= '0;
                post_de    <= pre_de;
                post_data  <= pre_data;
                state      <= EN ? RECV : BYPASS;
            end else begin
                case (state)
                    BYPASS: begin
                        post_de   <= pre_de;
                        post_data <= pre_data;
                    end
                    RECV: begin
                        if (pre_de) begin
                            h_cnt <= inc_h(idx);
                            if (idx < H_LIM) begin
                                post_de    <= 1'b1;
                                post_data  <= pre_data;
                                last_pix   <= pre_data;
                                trunc_seen <= 1'b0;
                            end else begin
                                post_de <= 1'b0;
                                if (!trunc_seen) begin
                                    trunc_cnt  <= inc_stat(trunc_cnt);
                                    trunc_seen <= 1'b1;
                                end
                            end
                        end else if (de_fall && h_cnt < H_LIM) begin
                            // First fill pixel goes out immediately behind the last real one.
                            pad_cnt   <= inc_stat(pad_cnt);
                            post_de   <= 1'b1;
                            post_data <= fill_val;
                            h_cnt     <= h_inc;
                            if (h_inc < H_LIM) state <= FILL;
                        end else begin
                            post_de <= 1'b0;
                        end
                    end
                    FILL: begin
                        if (de_rise) begin
                            ovr_flag   <= 1'b1;
                            post_de    <= 1'b1;
                            post_data  <= pre_data;
                            last_pix   <= pre_data;
                            trunc_seen <= 1'b0;
                            h_cnt      <= 12'd1;
                            state      <= RECV;
                        end else begin
                            post_de   <= 1'b1;
                            post_data <= fill_val;
                            h_cnt     <= h_inc;
                            if (h_inc >= H_LIM) state <= RECV;
                        end
                    end
                    default: state <= BYPASS;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_video_line_filler.sv
// Bench for video_line_filler: directed frame table with hand-derived statistics, reset
// corner case, and random frames checked against a line-level reference model.
module tb_video_line_filler;
    localparam int H    = 8;
    localparam int DW   = 24;
    localparam int SW   = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] color;
    logic          pre_vs;
    logic          pre_de;
    logic [DW-1:0] pre_data;
    logic          post_clk;
    logic          post_vs;
    logic          post_de;
    logic [DW-1:0] post_data;
    logic [SW-1:0] stat_pad;
    logic [SW-1:0] stat_trunc;
    logic          stat_ovr;

    video_line_filler #(.H_DISP(H), .DATA_W(DW), .STAT_W(SW)) dut (
        .pre_clk(clk), .rst(rst), .EN(en), .mode(mode), .color(color),
        .pre_vs(pre_vs), .pre_de(pre_de), .pre_data(pre_data),
        .post_clk(post_clk), .post_vs(post_vs), .post_de(post_de), .post_data(post_data),
        .stat_pad(stat_pad), .stat_trunc(stat_trunc), .stat_ovr(stat_ovr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_no = 0;
    int cyc = 0;
    int lens[16];
    int gaps[16];
    logic [DW-1:0] cap[$];
    int exp_pad, exp_trunc, exp_ovr;
    int m_pad, m_trunc, m_ovr;

    typedef struct {
        bit          en;
        logic [1:0]  md;
        logic [23:0] col;
        int          nl;
        int          len;
        int          gap;
        logic [23:0] seed;
        bit          tog;
        int          pad;
        int          trunc;
        int          ovr;
        int          ncap;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s frame %0d cycle %0d: got %0h expected %0h", name, frame_no, cyc, act, req);
        end
    endtask

    task automatic step(input logic vs, input logic de, input logic [DW-1:0] d);
        pre_vs = vs;
        pre_de = de;
        pre_data = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fill_ref(input logic [1:0] md, input logic [DW-1:0] col,
                                               input logic [DW-1:0] last);
        if (md == 2'b00) return last;
        if (md == 2'b01) return {DW{1'b0}};
        if (md == 2'b10) return {DW{1'b1}};
        return col;
    endfunction

    task automatic run_frame(input bit en_f, input logic [1:0] md, input logic [DW-1:0] col,
                             input int nl, input logic [DW-1:0] seed, input bit rnd,
                             input bit tog, input int tail);
        logic fvs[$];
        logic fde[$];
        logic [DW-1:0] fd[$];
        logic ede[$];
        logic [DW-1:0] edat[$];
        int starts[16];
        int n;
        for (int k = 0; k < 4; k++) begin
            fvs.push_back(k < 2); fde.push_back(1'b0); fd.push_back('0);
        end
        for (int i = 0; i < nl; i++) begin
            starts[i] = fde.size();
            for (int k = 0; k < lens[i]; k++) begin
                fvs.push_back(1'b0); fde.push_back(1'b1);
                fd.push_back(rnd ? DW'($urandom) : seed + DW'(k));
            end
            for (int k = 0; k < gaps[i]; k++) begin
                fvs.push_back(1'b0); fde.push_back(1'b0); fd.push_back('0);
            end
        end
        for (int k = 0; k < tail; k++) begin
            fvs.push_back(1'b0); fde.push_back(1'b0); fd.push_back('0);
        end
        n = fde.size();
        for (int t = 0; t < n; t++) begin
            ede.push_back(en_f ? 1'b0 : fde[t]);
            edat.push_back(en_f ? '0 : fd[t]);
        end
        m_pad = 0; m_trunc = 0; m_ovr = 0;
        if (en_f) begin
            for (int i = 0; i < nl; i++) begin
                int s, l, nx;
                logic [DW-1:0] fv;
                s = starts[i];
                l = lens[i];
                nx = (i + 1 < nl) ? starts[i+1] : n;
                for (int k = 0; k < l && k < H; k++) begin
                    ede[s+k] = 1'b1; edat[s+k] = fd[s+k];
                end
                if (l > H) m_trunc++;
                if (l < H) begin
                    m_pad++;
                    fv = fill_ref(md, col, fd[s+l-1]);
                    for (int t = s + l; t < s + H; t++) begin
                        if (t >= nx) begin
                            if (i + 1 < nl) m_ovr = 1;
                            break;
                        end
                        ede[t] = 1'b1; edat[t] = fv;
                    end
                end
            end
        end
        cap.delete();
        mode = md; color = col; en = en_f;
        for (int t = 0; t < n; t++) begin
            cyc = t;
            if (tog && t == n / 2) en = ~en_f;
            step(fvs[t], fde[t], fd[t]);
            check("vs_de", {30'd0, post_vs, post_de}, {30'd0, fvs[t], ede[t]});
            if (!en_f || ede[t]) check("data", 32'(post_data), 32'(edat[t]));
            if (post_de) cap.push_back(post_data);
            if (t == 0 || t == n - 1) begin
                check("stat_pad", 32'(stat_pad), 32'(exp_pad));
                check("stat_trunc", 32'(stat_trunc), 32'(exp_trunc));
                check("stat_ovr", 32'(stat_ovr), 32'(exp_ovr));
            end
        end
        frame_no++;
    endtask

    initial begin
        logic [DW-1:0] e0[8];
        e0 = '{24'hA, 24'hB, 24'hC, 24'hD, 24'hE, 24'h0, 24'h0, 24'h0};
        //             en md     col         nl len gap seed       tog pad tr ovr ncap
        tbl[0] = '{1, 2'b01, 24'h0,      1, 5,  4, 24'h00000A, 0, 1, 0, 0, 8};
        tbl[1] = '{1, 2'b00, 24'h0,      1, 5,  4, 24'h123452, 0, 1, 0, 0, 8};
        tbl[2] = '{1, 2'b01, 24'h0,      1, 10, 4, 24'h000100, 0, 0, 1, 0, 8};
        tbl[3] = '{1, 2'b01, 24'h0,      2, 3,  2, 24'h000300, 0, 2, 0, 1, 13};
        tbl[4] = '{1, 2'b10, 24'h0,      2, 8,  3, 24'h000200, 0, 0, 0, 0, 16};
        tbl[5] = '{1, 2'b11, 24'h5A5A5A, 3, 7,  1, 24'h000400, 0, 3, 0, 0, 24};
        tbl[6] = '{1, 2'b01, 24'h0,      2, 5,  4, 24'h000500, 1, 2, 0, 0, 16};
        tbl[7] = '{0, 2'b01, 24'h0,      2, 5,  4, 24'h000600, 0, 0, 0, 0, 10};
        tbl[8] = '{1, 2'b01, 24'h0,      9, 2,  6, 24'h000700, 0, 7, 0, 0, 72};

        rst = 1'b1; en = 1'b0; mode = 2'b00; color = '0;
        pre_vs = 1'b0; pre_de = 1'b0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_post_vs", 32'(post_vs), 32'd0);
        check("rst_post_de", 32'(post_de), 32'd0);
        check("rst_post_data", 32'(post_data), 32'd0);
        check("rst_stats", {29'd0, stat_pad}, 32'd0);
        check("rst_stat_ovr", {31'd0, stat_ovr}, 32'd0);
        rst = 1'b0;
        exp_pad = 0; exp_trunc = 0; exp_ovr = 0;

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < tbl[i].nl; j++) begin
                lens[j] = tbl[i].len; gaps[j] = tbl[i].gap;
            end
            run_frame(tbl[i].en, tbl[i].md, tbl[i].col, tbl[i].nl, tbl[i].seed, 1'b0, tbl[i].tog, 8);
            check("line_pixels", 32'(cap.size()), 32'(tbl[i].ncap));
            if (i == 0) begin
                for (int k = 0; k < 8; k++) check("black_fill_seq", 32'(cap[k]), 32'(e0[k]));
            end
            if (i == 1) begin
                for (int k = 5; k < 8; k++) check("repeat_fill", 32'(cap[k]), 32'h123456);
            end
            exp_pad = tbl[i].pad; exp_trunc = tbl[i].trunc; exp_ovr = tbl[i].ovr;
        end

        // Reset in the middle of a fill, then pass-through until EN is seen at a vsync rise.
        en = 1'b1; mode = 2'b01;
        step(1, 0, '0); step(1, 0, '0); step(0, 0, '0); step(0, 0, '0);
        step(0, 1, 24'h1); step(0, 1, 24'h2); step(0, 1, 24'h3);
        step(0, 0, '0);
        check("fill_before_rst", {31'd0, post_de}, 32'd1);
        rst = 1'b1;
        step(0, 0, '0);
        check("rst_fill_de", {31'd0, post_de}, 32'd0);
        check("rst_fill_data", 32'(post_data), 32'd0);
        check("rst_fill_vs", {31'd0, post_vs}, 32'd0);
        check("rst_fill_pad", {29'd0, stat_pad}, 32'd0);
        rst = 1'b0;
        step(0, 0, '0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 24'h50 + 24'(k));
            check("bypass_de", {31'd0, post_de}, 32'd1);
            check("bypass_data", 32'(post_data), 32'h50 + 32'(k));
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, '0);
            check("bypass_no_pad", {31'd0, post_de}, 32'd0);
        end
        exp_pad = 0; exp_trunc = 0; exp_ovr = 0;

        for (int f = 0; f < 30; f++) begin
            int nl;
            nl = $urandom_range(1, 4);
            for (int j = 0; j < nl; j++) begin
                lens[j] = $urandom_range(1, 12);
                gaps[j] = $urandom_range(1, 10);
            end
            run_frame(($urandom % 4) != 0, 2'($urandom), DW'($urandom), nl, '0, 1'b1,
                      1'($urandom), $urandom_range(0, 8));
            exp_pad   = (m_pad > SMAX) ? SMAX : m_pad;
            exp_trunc = (m_trunc > SMAX) ? SMAX : m_trunc;
            exp_ovr   = m_ovr;
        end
        run_frame(1'b0, 2'b00, '0, 0, '0, 1'b0, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
